hj_mod_counter: RTL and testbench

//  Parametrised modulo up/down counter; next generation of the free-running 7-bit counter pair.

---
 rtl/hj_mod_counter.sv | 83 ++++++++
 tb/tb_hj_mod_counter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hj_mod_counter.sv
// Modulo up/down counter with clamped parallel load, registered terminal-count pulse and wrap counter.
// Define COUNTER_SAT_EN to make the counter saturate at 0 and MAX_VAL rather than wrap.
module hj_mod_counter #(
   parameter int unsigned WIDTH   = 7,
   parameter int unsigned MAX_VAL = 127,
   parameter int unsigned WRAP_W  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up_dn,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  cnt,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              tc,
   output logic              at_max,
   output logic              at_zero
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0]  cnt_nxt;
   logic [WRAP_W-1:0] wrap_nxt;
   logic              tc_nxt;
   logic              top;
   logic              bottom;

   assign top    = (cnt == MAX_V);
   assign bottom = (cnt == '0);

   always_comb begin
      cnt_nxt  = cnt;
      wrap_nxt = wrap_cnt;
      tc_nxt   = 1'b0;
      if (load) begin
         cnt_nxt = (load_val > MAX_V) ? MAX_V : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (!top) begin
               cnt_nxt = cnt + WIDTH'(1);
            end else begin
`ifdef COUNTER_SAT_EN
               cnt_nxt = MAX_V;
`else
               cnt_nxt  = '0;
               wrap_nxt = wrap_cnt + WRAP_W'(1);
               tc_nxt   = 1'b1;
`endif
            end
         end else begin
            if (!bottom) begin
               cnt_nxt = cnt - WIDTH'(1);
            end else begin
`ifdef COUNTER_SAT_EN
               cnt_nxt = '0;
`else
               cnt_nxt  = MAX_V;
               wrap_nxt = wrap_cnt + WRAP_W'(1);
               tc_nxt   = 1'b1;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         wrap_cnt <= '0;
         tc       <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         wrap_cnt <= wrap_nxt;
         tc       <= tc_nxt;
      end
   end

   // Flags decode the registered count, so there is no input-to-output path.
   assign at_max  = top;
   assign at_zero = bottom;

endmodule

// File: tb/tb_hj_mod_counter.sv
// Scoreboard bench for hj_mod_counter (WIDTH=7, MAX_VAL=9, WRAP_W=3): directed scenarios then random traffic.
// The reference model follows COUNTER_SAT_EN the same way the design does.
module tb_hj_mod_counter;

   localparam int W     = 7;
   localparam int MAXV  = 9;
   localparam int WW    = 3;
   localparam int WRAPS = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          up_dn = 1'b1;
   logic          load = 1'b0;
   logic [W-1:0]  load_val = '0;
   logic [W-1:0]  cnt;
   logic [WW-1:0] wrap_cnt;
   logic          tc;
   logic          at_max;
   logic          at_zero;

   hj_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .WRAP_W(WW)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .cnt(cnt), .wrap_cnt(wrap_cnt), .tc(tc), .at_max(at_max), .at_zero(at_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    cnt;
      int    wrap;
      bit    tc;
      bit    amax;
      bit    azero;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   m_cnt = 0;
   int   m_wrap = 0;
   bit   m_tc = 0;

   task automatic step(input string tag, input bit r, input bit ld, input int lv,
                       input bit e, input bit u);
      exp_t x;
      @(negedge clk);
      rst = r; load = ld; load_val = W'(lv); en = e; up_dn = u;
      m_tc = 0;
      if (r) begin
         m_cnt = 0; m_wrap = 0;
      end else if (ld) begin
         m_cnt = (lv > MAXV) ? MAXV : lv;
      end else if (e) begin
         if (u && m_cnt < MAXV)       m_cnt = m_cnt + 1;
         else if (!u && m_cnt > 0)    m_cnt = m_cnt - 1;
         else begin
`ifndef COUNTER_SAT_EN
            m_cnt  = u ? 0 : MAXV;
            m_wrap = (m_wrap + 1) % WRAPS;
            m_tc   = 1;
`endif
         end
      end
      x.tag = tag; x.cnt = m_cnt; x.wrap = m_wrap; x.tc = m_tc;
      x.amax = (m_cnt == MAXV); x.azero = (m_cnt == 0);
      q.push_back(x);
   endtask

   // Monitor: each rising edge produces one observable state to check.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            n_vec++;
            if (int'(cnt) != x.cnt || int'(wrap_cnt) != x.wrap || tc !== x.tc ||
                at_max !== x.amax || at_zero !== x.azero) begin
               n_err++;
               $display("FAIL %s @%0t: got cnt=%0d wrap=%0d tc=%b max=%b zero=%b, want cnt=%0d wrap=%0d tc=%b max=%b zero=%b",
                        x.tag, $time, cnt, wrap_cnt, tc, at_max, at_zero,
                        x.cnt, x.wrap, x.tc, x.amax, x.azero);
            end
         end
      end
   end

   initial begin
      int r;
      // 1: reset then count up through a wrap
      step("reset", 1, 0, 0, 0, 1);
      step("reset", 1, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) step("up_wrap", 0, 0, 0, 1, 1);
      // 2: down from zero wraps to MAX
      step("reset", 1, 0, 0, 0, 1);
      step("down_wrap", 0, 0, 0, 1, 0);
      step("down_after", 0, 0, 0, 1, 0);
      step("hold", 0, 0, 0, 0, 0);
      // 3: load priority and clamping
      step("load5", 0, 1, 5, 1, 1);
      step("load_clamp", 0, 1, 100, 1, 0);
      step("load_max", 0, 1, 127, 0, 1);
      step("load9_wrap", 0, 1, 9, 0, 1);
      step("up_at_max", 0, 0, 0, 1, 1);
      step("load0", 0, 1, 0, 1, 0);
      step("dir_change", 0, 0, 0, 1, 1);
      step("dir_change", 0, 0, 0, 1, 0);
      // 4: 8 full wraps roll wrap_cnt over
      step("reset", 1, 0, 0, 0, 1);
      for (int i = 0; i < 80; i++) step("wrap_roll", 0, 0, 0, 1, 1);
      // 5: reset beats load and en
      step("load7", 0, 1, 7, 0, 1);
      step("rst_prio", 1, 1, 3, 1, 1);
      // 6: sustained push against both ends
      for (int i = 0; i < 15; i++) step("up15", 0, 0, 0, 1, 1);
      for (int i = 0; i < 15; i++) step("down15", 0, 0, 0, 1, 0);
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         step("random", (r < 2), (r >= 2 && r < 12), $urandom_range(0, 127),
              ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1);
      end
      step("idle", 0, 0, 0, 0, 1);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d expected states left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
